umi_tx_sim: RTL
===============

UMI_TX_SIM -- requirements
Module: umi_tx_sim

Interface
REQ-001 SHALL have parameter DEPTH, default 4: number of buffered packets when UMI_TX_SIM_FIFO_EN is defined; legal 2..16; ignored otherwise.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL have port packet, input, 256: UMI packet to transmit; bits [32i+31:32i] form word i, i=0..7.
REQ-005 SHALL have port valid, input, 1: packet is presented.
REQ-006 SHALL have port ready, output, 1: block can accept a packet this cycle.
REQ-007 SHALL have port sent_count, output, 32: number of packets successfully handed to the UMI queue.
REQ-008 SHALL provide an init(uri) task/function that opens the queue via pi_umi_init(id, uri, 1); the testbench calls it once before releasing rst.

Function
REQ-009 SHALL accept a packet on a rising edge where valid=1 and ready=1, storing all 256 bits at that edge.
REQ-010 SHALL hold ready = 1 exactly when rst=0 and buffer occupancy < capacity; occupancy is registered, with no same-cycle bypass from a pop.
REQ-011 SHALL, on each rising edge with rst=0 and occupancy > 0, call pi_umi_send(id, sbuf, success) once, with sbuf[i] = word i of the oldest stored packet.
REQ-012 SHALL pop the oldest packet and increment sent_count on that edge only if success == 1; otherwise the same packet is retried on the next edge, unchanged.
REQ-013 SHALL NOT call pi_umi_send when occupancy is 0 or rst=1.
REQ-014 SHALL give a minimum latency of one edge: a packet accepted at edge N is first offered at edge N+1.
REQ-015 SHALL preserve packet order; no packet is dropped, duplicated or reordered.
REQ-016 SHALL permit a push and a pop on the same edge; occupancy is then unchanged.
REQ-017 SHALL wrap FIFO read/write pointers modulo DEPTH.
REQ-018 SHALL wrap sent_count from 0xFFFFFFFF to 0.
REQ-019 SHALL ignore packet contents whenever valid=0 or ready=0.

Reset
REQ-020 SHALL, while rst=1, force occupancy=0, pointers=0, sent_count=0 and ready=0, independent of clk.
REQ-021 SHALL discard stored, unsent packets when rst asserts mid-operation; none are sent after rst deasserts.
REQ-022 SHALL set ready=1 on the first clk edge after rst deasserts; id and queue connection persist across reset.

Configuration
REQ-023 SHALL, with macro UMI_TX_SIM_FIFO_EN defined, buffer up to DEPTH packets in a circular FIFO.
REQ-024 SHALL, without UMI_TX_SIM_FIFO_EN, use a single holding register (capacity 1): ready = !full; a new packet is accepted only on an edge after the held packet is sent (no simultaneous push/pop).
REQ-025 SHALL keep all other requirements identical in both configurations.

Verification
REQ-026 Single packet: packet=0x...0008_0007_..._0001 (word i = i+1), valid for 1 cycle, queue accepting -> receiver gets words 1..8 in order; sent_count=1 one edge after acceptance.
REQ-027 Back-pressure: receiver side not draining, FIFO_EN, DEPTH=4, 6 packets offered -> ready falls after 4 accepted; draining then delivers packets 0..5 in order; sent_count=6.
REQ-028 Retry: first 3 send attempts fail -> the same packet is retried on 3 more edges, delivered exactly once; sent_count goes 0->1 only on the success edge.
REQ-029 Streaming: valid=1 continuously for 20 packets, queue always accepting, FIFO_EN -> one packet per cycle after the first; ready stays 1.
REQ-030 Reset mid-stream: 3 packets buffered, then rst pulsed -> ready=0 and sent_count=0 immediately; no buffered packet appears at the receiver; a new packet sent after reset arrives intact.
REQ-031 Non-FIFO build: two back-to-back valid packets -> ready=0 on the cycle after the first accept; second packet accepted only after the first is sent.

Source files
------------

// File: rtl/umi_tx_sim.sv
// umi_tx_sim: buffers 256-bit UMI packets and hands them, oldest first, to a simulated UMI queue.
// Build option UMI_TX_SIM_FIFO_EN selects a DEPTH-entry FIFO; otherwise a single holding register.
package umi_tx_sim_pkg;
    typedef logic [31:0] umi_words_t [8];

    // Loopback stand-in for the host-side UMI queue; acceptance and failures are steerable.
    int          open_id;
    bit          open_q;
    bit          accept_q;
    int          fail_q;
    int          calls_q;
    logic [31:0] rx_q [$];

    function automatic void pi_umi_init(input int id, input string uri, input int mode);
        open_id  = id;
        open_q   = (mode == 1) && (uri.len() > 0);
        accept_q = 1'b1;
        fail_q   = 0;
        calls_q  = 0;
        rx_q.delete();
    endfunction

    function automatic void pi_umi_send(input int id, input umi_words_t sbuf, output bit success);
        calls_q++;
        success = 1'b0;
        if (open_q && (id == open_id) && accept_q) begin
            if (fail_q > 0) begin
                fail_q--;
            end else begin
                for (int i = 0; i < 8; i++) rx_q.push_back(sbuf[i]);
                success = 1'b1;
            end
        end
    endfunction

    function automatic void umi_set_accept(input bit en);
        accept_q = en;
    endfunction

    function automatic void umi_set_fail(input int n);
        fail_q = n;
    endfunction

    function automatic int umi_rx_count();
        return rx_q.size();
    endfunction

    function automatic logic [31:0] umi_rx_pop();
        return rx_q.pop_front();
    endfunction

    function automatic int umi_calls();
        return calls_q;
    endfunction
endpackage

module umi_tx_sim #(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [255:0] packet,
    input  logic         valid,
    output logic         ready,
    output logic [31:0]  sent_count
);
    import umi_tx_sim_pkg::*;

    int           id;
    logic         push;
    logic [255:0] head;
    umi_words_t   head_words;

    function automatic void init(input string uri);
        id = 1;
        pi_umi_init(id, uri, 1);
    endfunction

    // One send attempt per call; the caller treats a true return as a completed pop.
    function automatic bit offer(input umi_words_t w);
        bit s;
        pi_umi_send(id, w, s);
        return s;
    endfunction

    always_comb begin
        for (int i = 0; i < 8; i++) head_words[i] = head[32*i +: 32];
    end

`ifdef UMI_TX_SIM_FIFO_EN
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [255:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    assign ready = !rst && (count < CW'(DEPTH));
    assign push  = valid && ready;
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= packet;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            sent_count <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            // Occupancy is sampled before this edge's push, so a new packet waits one edge.
            if ((count != '0) && offer(head_words)) begin
                rd_ptr     <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
                sent_count <= sent_count + 32'd1;
                if (!push) count <= count - 1'b1;
            end else if (push) begin
                count <= count + 1'b1;
            end
        end
    end
`else
    logic         full;
    logic [255:0] hold;

    assign ready = !rst && !full;
    assign push  = valid && ready;
    assign head  = hold;

    always_ff @(posedge clk) begin
        if (push) hold <= packet;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full       <= 1'b0;
            sent_count <= '0;
        end else if (full) begin
            if (offer(head_words)) begin
                full       <= 1'b0;
                sent_count <= sent_count + 32'd1;
            end
        end else if (push) begin
            full <= 1'b1;
        end
    end
`endif
endmodule
